// File: rtl/vga_mem_scanner.sv
// Background sweeper: reads a ROM or RAM window word by word through a
// low-priority arbiter read port and presents each word as a stable pair.
module vga_mem_scanner #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int unsigned WORDS    = 128,
  parameter int unsigned HOLD     = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        sel_ram,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_gnt,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic [31:0] MEM_Addr,
  output logic [31:0] MEM_Data,
  output logic        busy,
  output logic        frame_done
);

  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       FILLER    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               win_q, win_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rd_req_d;
  logic [31:0]        rd_addr_d;
  logic [31:0]        mem_addr_d, mem_data_d;
  logic               frame_done_d;

  logic last_word, hold_done, tmo_done;

  assign last_word = (idx_q == IDX_LAST);
  assign hold_done = (hold_q == HOLD_LAST);
  assign tmo_done  = (tmo_q == TMO_LAST);
  assign busy      = (state_q != S_IDLE);

  // NOTE: every next-value gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    win_d        = win_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    mem_addr_d   = MEM_Addr;
    mem_data_d   = MEM_Data;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_REQ;
          idx_d   = '0;
          win_d   = sel_ram;
        end
      end
      S_REQ: begin
        if (rd_gnt) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Real data wins even on the last allowed cycle; filler only on silence.
        if (rd_valid || tmo_done) begin
          mem_data_d = rd_valid ? rd_data : FILLER;
          mem_addr_d = 32'({idx_q, 2'b00});
          hold_d     = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_done) begin
          frame_done_d = last_word;
          idx_d        = last_word ? '0 : idx_q + IDX_W'(1);
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_REQ;
            // A fresh sweep (wrap or window change) re-latches the window.
            if (last_word || (sel_ram != win_q)) begin
              idx_d = '0;
              win_d = sel_ram;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_req_d  = (state_d == S_REQ);
    rd_addr_d = rd_req_d ? ((win_d ? RAM_BASE : ROM_BASE) + 32'({idx_d, 2'b00}))
                         : rd_addr;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      win_q      <= 1'b0;
      tmo_q      <= '0;
      hold_q     <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      MEM_Addr   <= '0;
      MEM_Data   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      rd_req     <= rd_req_d;
      rd_addr    <= rd_addr_d;
      MEM_Addr   <= mem_addr_d;
      MEM_Data   <= mem_data_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
